cond_flag_unit: RTL and testbench

Conditional-execution and flag-holding block for the single-cycle ARM datapath. It sits between the ALU and the main decoder. It captures the ALU's NZCV result into an architectural flag register under control of the decoder's flag-write request, and evaluates each instruction's Cond field against the stored flags. It then gates the decoder's raw write/branch requests into the final RegWrite, MemWrite and PCSrc strobes. It also counts executed and condition-skipped instructions for bring-up.

---
 rtl/cond_flag_unit.sv | 112 +++++++++++
 tb/tb_cond_flag_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// ============================================================================
// Module  : cond_flag_unit
// Brief   : NZCV flag register, ARM condition evaluation, gating of the
//           write/branch strobes and executed/skipped instruction counters.
//           Define COND_FULL_EN to decode all 16 condition codes
//           (otherwise only EQ, NE and AL are decoded).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             PCS,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_cond_ex;
  logic w_strobe_en;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition is always evaluated against the stored flags, never ALUFlags,
  // so a flag-setting conditional instruction tests the previous result.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
`ifdef COND_FULL_EN
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
`else
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
`endif
    endcase
  end

  // Reset overrides the strobes combinationally, not just at the next edge.
  assign w_strobe_en = InstrValid & w_cond_ex & ~reset;

  assign CondEx    = w_cond_ex;
  assign RegWrite  = RegW & ~NoWrite & w_strobe_en;
  assign MemWrite  = MemW & w_strobe_en;
  assign PCSrc     = PCS & w_strobe_en;
  assign Flags     = r_flags;
  assign ExecCount = r_exec_cnt;
  assign SkipCount = r_skip_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (InstrValid && w_cond_ex) begin
      if (FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exec_cnt <= '0;
      r_skip_cnt <= '0;
    end else if (InstrValid) begin
      if (w_cond_ex) r_exec_cnt <= r_exec_cnt + 1'b1;
      else           r_skip_cnt <= r_skip_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
// ============================================================================
// Module  : tb_cond_flag_unit
// Brief   : Directed self-checking bench for cond_flag_unit (CNT_W = 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_flag_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             InstrValid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             RegW;
  logic             MemW;
  logic             PCS;
  logic             NoWrite;
  logic             CondEx;
  logic             RegWrite;
  logic             MemWrite;
  logic             PCSrc;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SkipCount;

  int checks = 0;
  int errors = 0;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrValid (InstrValid),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .RegW       (RegW),
    .MemW       (MemW),
    .PCS        (PCS),
    .NoWrite    (NoWrite),
    .CondEx     (CondEx),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .PCSrc      (PCSrc),
    .Flags      (Flags),
    .ExecCount  (ExecCount),
    .SkipCount  (SkipCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic rw, input logic mw,
                       input logic pcs, input logic nw);
    InstrValid = v;
    Cond       = c;
    ALUFlags   = alu;
    FlagW      = fw;
    RegW       = rw;
    MemW       = mw;
    PCS        = pcs;
    NoWrite    = nw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid AL instruction optionally writing flags, then clocked.
  task automatic al_instr(input logic [3:0] alu, input logic [1:0] fw);
    drive(1'b1, 4'b1110, alu, fw, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  logic full;

  initial begin
`ifdef COND_FULL_EN
    full = 1'b1;
`else
    full = 1'b0;
`endif
    reset = 1'b1;
    drive(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    // Reset state: strobes forced low even with raw requests high
    chk("rst_flags", Flags, 4'b0000);
    chk("rst_exec", ExecCount, 0);
    chk("rst_skip", SkipCount, 0);
    chk("rst_eq", CondEx, 0);
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_pcsrc", PCSrc, 0);
    drive(1'b0, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_ne", CondEx, 1);
    reset = 1'b0;
    tick();

    // CMP then BEQ
    drive(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("cmp_condex", CondEx, 1);
    chk("cmp_regwrite", RegWrite, 0);
    tick();
    chk("cmp_flags", Flags, 4'b0100);
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("beq_pcsrc", PCSrc, 1);
    tick();
    chk("beq_exec", ExecCount, 2);

    // Failed condition: clear Z, then EQ with writes requested
    al_instr(4'b0000, 2'b11);
    drive(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("eqfail_condex", CondEx, 0);
    chk("eqfail_regwrite", RegWrite, 0);
    chk("eqfail_memwrite", MemWrite, 0);
    tick();
    chk("eqfail_flags", Flags, 4'b0000);
    chk("eqfail_skip", SkipCount, 1);
    chk("eqfail_exec", ExecCount, 3);

    // NE passes with Z=0: memory write and register write go through
    drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ne_memwrite", MemWrite, 1);
    chk("ne_regwrite", RegWrite, 1);
    tick();
    chk("ne_exec", ExecCount, 4);

    // Partial flag writes, each half independent
    al_instr(4'b1111, 2'b11);
    chk("pw_all", Flags, 4'b1111);
    al_instr(4'b0000, 2'b10);
    chk("pw_nz", Flags, 4'b0011);
    al_instr(4'b1110, 2'b01);
    chk("pw_cv", Flags, 4'b0010);
    chk("pw_exec", ExecCount, 7);

    // Signed conditions with N=1, V=0 (also C=0, Z=0)
    al_instr(4'b1000, 2'b11);
    chk("sg_flags", Flags, 4'b1000);
    drive(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sg_ge", CondEx, 0);
    drive(1'b0, 4'b1011, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sg_lt", CondEx, {31'b0, full});
    drive(1'b0, 4'b1100, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sg_gt", CondEx, 0);
    drive(1'b0, 4'b1101, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sg_le", CondEx, {31'b0, full});
    drive(1'b0, 4'b0100, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("sg_mi", CondEx, {31'b0, full});
    drive(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("nv_condex", CondEx, 0);

    // Invalid cycle with raw requests high and a passing condition
    drive(1'b0, 4'b1110, 4'b0111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("inv_regwrite", RegWrite, 0);
    chk("inv_memwrite", MemWrite, 0);
    chk("inv_pcsrc", PCSrc, 0);
    tick();
    tick();
    chk("inv_flags", Flags, 4'b1000);
    chk("inv_exec", ExecCount, 8);
    chk("inv_skip", SkipCount, 1);

    // Counter wrap: 8 more executed instructions bring 4-bit count to 0
    for (int i = 0; i < 8; i++) al_instr(4'b0000, 2'b00);
    chk("wrap_exec", ExecCount, 0);

    // Mid-run async reset with Flags=1010 and ExecCount=5
    al_instr(4'b1010, 2'b11);
    for (int i = 0; i < 4; i++) al_instr(4'b0000, 2'b00);
    chk("pre_rst_flags", Flags, 4'b1010);
    chk("pre_rst_exec", ExecCount, 5);
    drive(1'b1, 4'b1110, 4'b0101, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_regwrite", RegWrite, 1);
    reset = 1'b1;
    #1;
    chk("async_flags", Flags, 4'b0000);
    chk("async_exec", ExecCount, 0);
    chk("async_skip", SkipCount, 0);
    chk("async_regwrite", RegWrite, 0);
    chk("async_pcsrc", PCSrc, 0);
    tick();
    chk("held_flags", Flags, 4'b0000);
    reset = 1'b0;

    // Full 16-instruction wrap from zero
    for (int i = 0; i < 15; i++) al_instr(4'b0000, 2'b00);
    chk("wrap15_exec", ExecCount, 15);
    al_instr(4'b0000, 2'b00);
    chk("wrap16_exec", ExecCount, 0);
    chk("wrap16_skip", SkipCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
